// File: rtl/pipe_stage_ctrl_if.sv
// pipe_stage_ctrl_if: hazard inputs and stage enable/flush outputs of the pipeline stall/flush controller
interface pipe_stage_ctrl_if;
    logic       load_use_i;
    logic       branch_taken_i;
    logic       mdu_start_i;
    logic       int_req_i;
    logic       eret_wb_i;
    logic       halt_i;
    logic       pc_en_o;
    logic       ifid_en_o;
    logic       idex_en_o;
    logic       exmem_en_o;
    logic       memwb_en_o;
    logic       ifid_flush_o;
    logic       idex_flush_o;
    logic       exmem_flush_o;
    logic       memwb_flush_o;
    logic       int_take_o;
    logic       mdu_busy_o;
    logic [2:0] state_o;

    modport master (
        output load_use_i, branch_taken_i, mdu_start_i, int_req_i, eret_wb_i, halt_i,
        input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
        input  ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
        input  int_take_o, mdu_busy_o, state_o
    );

    modport slave (
        input  load_use_i, branch_taken_i, mdu_start_i, int_req_i, eret_wb_i, halt_i,
        output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o,
        output ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
        output int_take_o, mdu_busy_o, state_o
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: 5-stage pipeline stall/flush sequencer; define PIPE_CTRL_INT_EN to enable the interrupt drain/entry path
module pipe_stage_ctrl #(
    parameter int MDU_LAT   = 32,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stage_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        RUN     = 3'd0,
        MDU     = 3'd1,
        DRAIN   = 3'd2,
        INTTAKE = 3'd3,
        HALT    = 3'd4
    } state_e;

`ifdef PIPE_CTRL_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    localparam logic [7:0] MDU_CNT   = 8'(MDU_LAT - 1);
    localparam logic [7:0] DRAIN_CNT = 8'(DRAIN_CYC - 1);

    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem, memwb}
    localparam logic [4:0] EN_MDU   = 5'b00001;
    localparam logic [3:0] FL_MDU   = 4'b0010;
    localparam logic [4:0] EN_BUB   = 5'b00111;
    localparam logic [3:0] FL_BUB   = 4'b0100;
    localparam logic [3:0] FL_ERET  = 4'b1110;
    localparam logic [3:0] FL_BRANCH = 4'b1100;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] en;
    logic [3:0] fl;
    logic       take, busy;

    // state and countdown registers
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // next state and per-stage enable/flush decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en      = '1;
        fl      = '0;
        take    = 1'b0;
        busy    = 1'b0;
        if (rst) begin
            en      = '0;
            fl      = '1;
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.halt_i) begin
                        en      = '0;
                        state_d = HALT;
                    end else if (bus.eret_wb_i) begin
                        fl = FL_ERET;
                    end else if (bus.branch_taken_i) begin
                        fl = FL_BRANCH;
                    end else if (bus.mdu_start_i) begin
                        en      = EN_MDU;
                        fl      = FL_MDU;
                        cnt_d   = MDU_CNT;
                        state_d = MDU;
                    end else if (bus.int_req_i && INT_EN) begin
                        en      = EN_BUB;
                        fl      = FL_BUB;
                        cnt_d   = DRAIN_CNT;
                        state_d = DRAIN;
                    end else if (bus.load_use_i) begin
                        en = EN_BUB;
                        fl = FL_BUB;
                    end
                end
                MDU: begin
                    if (cnt_q != 8'd0) begin
                        en    = EN_MDU;
                        fl    = FL_MDU;
                        busy  = 1'b1;
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (bus.eret_wb_i) begin
                        fl      = FL_ERET;
                        state_d = RUN;
                    end else if (bus.branch_taken_i) begin
                        fl      = FL_BRANCH;
                        state_d = RUN;
                    end else begin
                        en = EN_BUB;
                        fl = FL_BUB;
                        if (cnt_q == 8'd0) state_d = INTTAKE;
                        else cnt_d = cnt_q - 8'd1;
                    end
                end
                INTTAKE: begin
                    take    = INT_EN;
                    fl      = '1;
                    state_d = RUN;
                end
                HALT: en = '0;
                default: state_d = RUN;
            endcase
        end
    end

    assign {bus.pc_en_o, bus.ifid_en_o, bus.idex_en_o, bus.exmem_en_o, bus.memwb_en_o} = en;
    assign {bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_flush_o} = fl;
    assign bus.int_take_o = take;
    assign bus.mdu_busy_o = busy;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: scoreboard bench for pipe_stage_ctrl with MDU_LAT=4, DRAIN_CYC=3
module tb_pipe_stage_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [13:0] sb[$];

    pipe_stage_ctrl_if bus();

    pipe_stage_ctrl #(.MDU_LAT(4), .DRAIN_CYC(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // input codes: {halt, eret, branch, mdu, int, load_use}
    localparam logic [5:0] I0 = 6'b000000, LU = 6'b000001, IR = 6'b000010, MS = 6'b000100;
    localparam logic [5:0] BR = 6'b001000, ER = 6'b010000, HL = 6'b100000;

    // expected word: {en[4:0], flush[3:0], int_take, mdu_busy, state[2:0]}
    function automatic logic [13:0] e(logic [4:0] en, logic [3:0] fl, logic tk, logic bz, logic [2:0] st);
        return {en, fl, tk, bz, st};
    endfunction

    task automatic check(string tag, logic [13:0] got, logic [13:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got en=%b fl=%b take=%b busy=%b st=%0d, expected en=%b fl=%b take=%b busy=%b st=%0d",
                     tag, got[13:9], got[8:5], got[4], got[3], got[2:0],
                     exp[13:9], exp[8:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic cyc(string tag, logic r, logic [5:0] in, logic [13:0] exp);
        rst = r;
        {bus.halt_i, bus.eret_wb_i, bus.branch_taken_i, bus.mdu_start_i, bus.int_req_i, bus.load_use_i} = in;
        sb.push_back(exp);
        @(negedge clk);
        check(tag, {bus.pc_en_o, bus.ifid_en_o, bus.idex_en_o, bus.exmem_en_o, bus.memwb_en_o,
                    bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o, bus.memwb_flush_o,
                    bus.int_take_o, bus.mdu_busy_o, bus.state_o}, sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] adv, bub, mdu_e;
        adv   = e(5'b11111, 4'b0000, 1'b0, 1'b0, 3'd0);
        bub   = e(5'b00111, 4'b0100, 1'b0, 1'b0, 3'd0);
        mdu_e = e(5'b00001, 4'b0010, 1'b0, 1'b0, 3'd0);
        {bus.halt_i, bus.eret_wb_i, bus.branch_taken_i, bus.mdu_start_i, bus.int_req_i, bus.load_use_i} = I0;
        @(posedge clk);
        #1;
        cyc("rst",        1'b1, HL | MS, e(5'b00000, 4'b1111, 1'b0, 1'b0, 3'd0));
        cyc("idle",       1'b0, I0, adv);
        cyc("load_use",   1'b0, LU, bub);
        cyc("lu_once",    1'b0, I0, adv);
        cyc("br_over_lu", 1'b0, BR | LU | MS, e(5'b11111, 4'b1100, 1'b0, 1'b0, 3'd0));
        cyc("br_after",   1'b0, I0, adv);
        cyc("eret",       1'b0, ER, e(5'b11111, 4'b1110, 1'b0, 1'b0, 3'd0));
        cyc("eret_br",    1'b0, ER | BR | MS, e(5'b11111, 4'b1110, 1'b0, 1'b0, 3'd0));
        cyc("mdu_entry",  1'b0, MS | IR | LU, mdu_e);
        cyc("mdu_c3",     1'b0, IR | LU, e(5'b00001, 4'b0010, 1'b0, 1'b1, 3'd1));
        cyc("mdu_c2",     1'b0, LU, e(5'b00001, 4'b0010, 1'b0, 1'b1, 3'd1));
        cyc("mdu_c1",     1'b0, I0, e(5'b00001, 4'b0010, 1'b0, 1'b1, 3'd1));
        cyc("mdu_c0",     1'b0, LU, e(5'b11111, 4'b0000, 1'b0, 1'b0, 3'd1));
        cyc("mdu_done",   1'b0, I0, adv);
        cyc("mdu_rst_in", 1'b0, MS, mdu_e);
        cyc("mdu_rst_c3", 1'b0, I0, e(5'b00001, 4'b0010, 1'b0, 1'b1, 3'd1));
        cyc("mdu_rst",    1'b1, I0, e(5'b00000, 4'b1111, 1'b0, 1'b0, 3'd1));
        cyc("mdu_rst_ok", 1'b0, I0, adv);
`ifdef PIPE_CTRL_INT_EN
        cyc("int_acc",    1'b0, IR | LU, bub);
        cyc("drain_1",    1'b0, IR, e(5'b00111, 4'b0100, 1'b0, 1'b0, 3'd2));
        cyc("drain_2",    1'b0, IR, e(5'b00111, 4'b0100, 1'b0, 1'b0, 3'd2));
        cyc("drain_3",    1'b0, I0, e(5'b00111, 4'b0100, 1'b0, 1'b0, 3'd2));
        cyc("int_take",   1'b0, I0, e(5'b11111, 4'b1111, 1'b1, 1'b0, 3'd3));
        cyc("int_ret",    1'b0, I0, adv);
        cyc("int_acc2",   1'b0, IR, bub);
        cyc("drain2_1",   1'b0, IR, e(5'b00111, 4'b0100, 1'b0, 1'b0, 3'd2));
        cyc("drain_br",   1'b0, IR | BR, e(5'b11111, 4'b1100, 1'b0, 1'b0, 3'd2));
        cyc("reaccept",   1'b0, IR, bub);
        cyc("drain_eret", 1'b0, IR | ER, e(5'b11111, 4'b1110, 1'b0, 1'b0, 3'd2));
        cyc("eret_ret",   1'b0, I0, adv);
        cyc("mdu_vs_int", 1'b0, IR | MS, mdu_e);
        cyc("mdu_vs_c3",  1'b0, I0, e(5'b00001, 4'b0010, 1'b0, 1'b1, 3'd1));
        cyc("mdu_vs_rst", 1'b1, I0, e(5'b00000, 4'b1111, 1'b0, 1'b0, 3'd1));
        cyc("int_acc3",   1'b0, IR, bub);
        cyc("drain_rst",  1'b1, IR, e(5'b00000, 4'b1111, 1'b0, 1'b0, 3'd2));
        cyc("no_take",    1'b0, I0, adv);
`else
        cyc("int_ign_1",  1'b0, IR, adv);
        cyc("int_ign_2",  1'b0, IR | LU, bub);
        cyc("int_ign_3",  1'b0, IR, adv);
`endif
        cyc("halt",       1'b0, HL | ER | BR, e(5'b00000, 4'b0000, 1'b0, 1'b0, 3'd0));
        cyc("halt_1",     1'b0, ER | BR, e(5'b00000, 4'b0000, 1'b0, 1'b0, 3'd4));
        cyc("halt_2",     1'b0, MS | IR | LU, e(5'b00000, 4'b0000, 1'b0, 1'b0, 3'd4));
        cyc("halt_3",     1'b0, I0, e(5'b00000, 4'b0000, 1'b0, 1'b0, 3'd4));
        cyc("halt_rst",   1'b1, I0, e(5'b00000, 4'b1111, 1'b0, 1'b0, 3'd4));
        cyc("after_rst",  1'b0, I0, adv);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline. Drives the enable and flush (synchronous clear) inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sequences load-use stalls, taken-branch flushes, multi-cycle MDU (mult/div) stalls, interrupt drain/entry, ERET redirect and halt. Pipeline registers keep their own data paths. This block only decides, every cycle, which stage advances, holds or is bubbled.

## Interface
Parameters:
- MDU_LAT, 32, number of stall cycles a mult/div holds EX; legal range 1..255
- DRAIN_CYC, 3, cycles spent retiring older instructions before interrupt entry; legal range 1..7

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- load_use_i  in  1  ID instruction reads the register loaded by the EX-stage load
- branch_taken_i  in  1  EX resolved a taken branch/jump
- mdu_start_i  in  1  EX holds a mult/div needing MDU_LAT cycles
- int_req_i  in  1  level; enabled interrupt pending
- eret_wb_i  in  1  ERET in WB
- halt_i  in  1  halt (syscall) in WB
- pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o  out  1 each  register load enables
- ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o  out  1 each  clear register to bubble at next edge; flush overrides enable
- int_take_o  out  1  one-cycle pulse: PC loads vector, EPC captured from IF/ID PC, IE closed
- mdu_busy_o  out  1  high in MDU state
- state_o  out  3  RUN=0, MDU=1, DRAIN=2, INTTAKE=3, HALT=4

## Operation
- Registered: state and an 8-bit down-counter cnt. All outputs are combinational from state, cnt and inputs.
- rst cycle: all en_o=0, all flush_o=1, int_take_o=0, mdu_busy_o=0. Next state is RUN with cnt=0.
- Default advance: all en_o=1, all flush_o=0.
- RUN priority, highest first:
  - halt_i: all en=0, go HALT.
  - eret_wb_i: pc_en=1 (PC loads EPC); flush ifid, idex and exmem.
  - branch_taken_i: advance; ifid_flush=1, idex_flush=1. load_use_i and mdu_start_i are ignored because they come from wrong-path or already-resolved instructions.
  - mdu_start_i: pc/ifid/idex/exmem en=0; exmem_flush=1; memwb en=1. Set cnt=MDU_LAT-1 and go MDU.
  - int_req_i: enter DRAIN with cnt=DRAIN_CYC-1, applying DRAIN outputs this cycle.
  - load_use_i: pc_en=0, ifid_en=0, idex_flush=1; rest advance.
  - Otherwise: default advance.
- MDU: outputs as in the mdu_start cycle while cnt≠0; cnt decrements each cycle. At cnt=0: default advance, go RUN. int_req_i and load_use_i are ignored until RUN.
- DRAIN:
  - Outputs: pc_en=0, ifid_en=0 (held instruction becomes EPC), idex_flush=1, exmem/memwb advance.
  - branch_taken_i or eret_wb_i in DRAIN: apply that RUN action and return to RUN (drain aborted; interrupt re-accepted later since level).
  - int_req_i dropping does not abort.
  - At cnt=0: go INTTAKE. Otherwise decrement cnt.
- INTTAKE: int_take_o=1, pc_en=1, all four flush=1. Go RUN.
- HALT: all en=0, flush=0. Stays in HALT until rst.

## Timing
- Load-use: exactly one bubble per assertion.
- Branch: 2-cycle penalty.
- MDU: EX held MDU_LAT cycles including the entry cycle; the instruction leaves EX on the cnt=0 cycle.
- Interrupt: vector fetched DRAIN_CYC+1 cycles after acceptance.
- ERET: 3-instruction flush, redirect the same cycle.
- rst mid-MDU/DRAIN: state goes to RUN next cycle; no int_take_o pulse.

## Configuration
- PIPE_CTRL_INT_EN defined: interrupt path as above.
- Undefined: int_req_i ignored, DRAIN/INTTAKE unreachable, int_take_o tied 0; ERET still handled.

## Test plan
- load_use_i=1 one cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1 that cycle only; state_o stays 0.
- branch_taken_i=1 with load_use_i=1 -> ifid_flush=idex_flush=1, pc_en=1, no stall.
- MDU_LAT=4, mdu_start_i pulse -> mdu_busy_o high 3 cycles. EX held 4 cycles total. exmem_flush=1 for 4 cycles, then RUN.
- PIPE_CTRL_INT_EN, DRAIN_CYC=3, int_req_i held -> states 2,2,2,3,0; int_take_o high on the 4th cycle with all flushes=1.
- branch_taken_i in 2nd DRAIN cycle -> branch flush, state 0, then re-enters DRAIN next cycle.
- halt_i -> state 4, all en=0 indefinitely. rst -> all flush=1 that cycle, state 0 after.
